ads_ctrl: RTL and testbench

ADS_CTRL -- requirements
Module: ads_ctrl

---
 rtl/ads_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ads_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads_ctrl.sv
// I2C master for an ADS1115: writes the config register on wr_req and reads the
// conversion register on rd_req. One bit = four equal quarters of the divider.
module ads_ctrl #(
  parameter int          SYS_CLK_HZ = 10_000_000,
  parameter int          SCL_HZ     = 100_000,
  parameter logic [6:0]  SLAVE_ADDR = 7'h48,
  parameter logic [15:0] CFG_WORD   = 16'h8483
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic        rd_req,
  output logic [15:0] ad_voltage,
  output logic        ads_scl,
  inout  wire         ads_sda
);

  localparam int BIT_CYC = SYS_CLK_HZ / SCL_HZ;
  localparam int QTR     = BIT_CYC / 4;
  localparam int DW      = $clog2(BIT_CYC);
  localparam logic [DW-1:0] Q1   = DW'(QTR);
  localparam logic [DW-1:0] Q2   = DW'(2 * QTR);
  localparam logic [DW-1:0] Q3   = DW'(3 * QTR);
  localparam logic [DW-1:0] LAST = DW'(BIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, START, TX_BYTE, RX_ACK, RX_BYTE, TX_ACK, STOP, RESTART
  } state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [2:0]    bit_cnt;
  logic [2:0]    byte_idx;
  logic          is_rd;
  logic          abort;
  logic          ack_bit;
  logic [7:0]    shreg;
  logic [7:0]    msb;
  logic          scl_q;
  logic          sda_low;

  logic [1:0]    qtr;
  logic [7:0]    tx_byte;
  logic          bus_scl;
  logic          bus_low;
  logic          last;
  logic          smp;
  logic          sda_in;

  assign ads_sda = sda_low ? 1'b0 : 1'bz;
  assign ads_scl = scl_q;
  assign sda_in  = ads_sda;
  assign last    = (div == LAST);
  assign smp     = (div == Q2);

  always_comb begin
    if (div < Q1)      qtr = 2'd0;
    else if (div < Q2) qtr = 2'd1;
    else if (div < Q3) qtr = 2'd2;
    else               qtr = 2'd3;
  end

  // byte_idx walks the transaction: write uses 0..3, read uses 0..1, then 2 after the restart
  always_comb begin
    tx_byte = {SLAVE_ADDR, 1'b0};
    case (byte_idx)
      3'd1:    tx_byte = is_rd ? 8'h00 : 8'h01;
      3'd2:    tx_byte = is_rd ? {SLAVE_ADDR, 1'b1} : CFG_WORD[15:8];
      3'd3:    tx_byte = CFG_WORD[7:0];
      default: tx_byte = {SLAVE_ADDR, 1'b0};
    endcase
  end

  always_comb begin
    bus_scl = (qtr == 2'd1) || (qtr == 2'd2);
    bus_low = 1'b0;
    case (state)
      IDLE, RESTART: bus_scl = 1'b1;
      START: begin
        bus_scl = (qtr != 2'd3);
        bus_low = qtr[1];
      end
      TX_BYTE: bus_low = ~tx_byte[3'd7 - bit_cnt];
      TX_ACK:  bus_low = (byte_idx == 3'd3);
      // STOP: first bit holds SDA low under a clock pulse, second bit is the release edge plus idle time
      STOP: begin
        if (bit_cnt == 3'd0) begin
          bus_scl = (qtr != 2'd0);
          bus_low = 1'b1;
        end else begin
          bus_scl = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div        <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      is_rd      <= 1'b0;
      abort      <= 1'b0;
      ack_bit    <= 1'b0;
      shreg      <= '0;
      msb        <= '0;
      ad_voltage <= '0;
      scl_q      <= 1'b1;
      sda_low    <= 1'b0;
    end else begin
      scl_q   <= bus_scl;
      sda_low <= bus_low;
      if (state == IDLE) begin
        div      <= '0;
        bit_cnt  <= '0;
        byte_idx <= '0;
        abort    <= 1'b0;
        if (wr_req || rd_req) begin
          state <= START;
          is_rd <= ~wr_req;
        end
      end else begin
        div <= last ? '0 : div + DW'(1);
        if (smp) begin
          ack_bit <= sda_in;
          if (state == RX_BYTE) shreg <= {shreg[6:0], sda_in};
        end
        if (last) begin
          case (state)
            START: begin
              state   <= TX_BYTE;
              bit_cnt <= '0;
            end
            TX_BYTE: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= RX_ACK;
            end
            RX_BYTE: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= TX_ACK;
            end
            RX_ACK: begin
              bit_cnt <= '0;
              if (ack_bit) begin
                abort <= 1'b1;
                state <= STOP;
              end else begin
                byte_idx <= byte_idx + 3'd1;
                if (!is_rd)                  state <= (byte_idx == 3'd3) ? STOP : TX_BYTE;
                else if (byte_idx == 3'd0)   state <= TX_BYTE;
                else if (byte_idx == 3'd1)   state <= STOP;
                else                         state <= RX_BYTE;
              end
            end
            TX_ACK: begin
              bit_cnt <= '0;
              if (byte_idx == 3'd3) begin
                msb      <= shreg;
                byte_idx <= 3'd4;
                state    <= RX_BYTE;
              end else begin
                byte_idx <= 3'd5;
                state    <= STOP;
              end
            end
            STOP: begin
              if (bit_cnt == 3'd0) begin
                bit_cnt <= 3'd1;
              end else begin
                bit_cnt <= '0;
                if (is_rd && !abort && byte_idx == 3'd2) begin
                  state <= RESTART;
                end else begin
                  state <= IDLE;
                  if (is_rd && !abort && byte_idx == 3'd5) ad_voltage <= {msb, shreg};
                end
              end
            end
            RESTART: state <= START;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ads_ctrl.sv
// Bench for ads_ctrl: an event-level I2C slave feeds observed bus events to a
// monitor that compares them against a transaction-level reference model.
`timescale 1ns/1ps
module tb_ads_ctrl;

  localparam logic [3:0] EV_S = 4'h1;  // START
  localparam logic [3:0] EV_P = 4'h2;  // STOP
  localparam logic [3:0] EV_B = 4'h3;  // byte written by master
  localparam logic [3:0] EV_A = 4'h4;  // master ack bit after a read byte
  localparam logic [3:0] EV_V = 4'h5;  // ad_voltage change

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_req = 1'b0;
  logic        rd_req = 1'b0;
  logic [15:0] ad_voltage;
  logic        ads_scl;
  wire         sda_bus;
  logic        slave_low = 1'b0;

  assign sda_bus = slave_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  ads_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_req(wr_req),
    .rd_req(rd_req),
    .ad_voltage(ad_voltage),
    .ads_scl(ads_scl),
    .ads_sda(sda_bus)
  );

  always #50 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          edge_cnt = 0;
  int          last_stop = 0;
  int          nack_at = -1;
  int          txn_id = 0;
  logic        slave_en = 1'b0;
  logic [7:0]  tx_msb = 8'h00;
  logic [7:0]  tx_lsb = 8'h00;
  logic [15:0] model_v = 16'h0000;
  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];
  int          obs_t[$];

  always @(posedge clk) cyc++;
  always @(ads_scl or sda_bus) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    n_checks++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d..%0d", name, v, lo, hi);
    end
  endtask

  function automatic void push_ev(input logic [3:0] k, input logic [15:0] d);
    exp_q.push_back({k, d});
  endfunction

  // Slave: decodes START/STOP/bits from bus levels, ACKs unless told to NACK, serves tx_msb/tx_lsb
  initial begin : slave
    logic p_scl, p_sda, s_tx, s_go_tx, m_ack;
    logic [7:0] s_byte, cur;
    int s_pos, s_rx_cnt, s_byte_no, s_txn, s_tx_idx;
    p_scl = 1'b1; p_sda = 1'b1; s_tx = 1'b0; s_go_tx = 1'b0; m_ack = 1'b1;
    s_byte = 8'h00; cur = 8'h00;
    s_pos = 0; s_rx_cnt = 0; s_byte_no = 0; s_txn = 0; s_tx_idx = 0;
    forever begin
      @(ads_scl or sda_bus or slave_en);
      if (!slave_en) begin
        s_pos = 0; s_tx = 1'b0; s_go_tx = 1'b0; slave_low = 1'b0;
      end else if (ads_scl && p_scl && p_sda && !sda_bus) begin
        if (s_txn != txn_id) begin
          s_txn = txn_id;
          s_rx_cnt = 0;
        end
        s_pos = 0; s_byte_no = 0; s_tx = 1'b0; s_go_tx = 1'b0; slave_low = 1'b0;
        obs_q.push_back({EV_S, 16'h0000}); obs_t.push_back(cyc);
      end else if (ads_scl && p_scl && !p_sda && sda_bus) begin
        s_pos = 0; s_tx = 1'b0; s_go_tx = 1'b0; slave_low = 1'b0;
        obs_q.push_back({EV_P, 16'h0000}); obs_t.push_back(cyc);
      end else if (ads_scl && !p_scl) begin
        if (s_pos < 8) begin
          s_byte = {s_byte[6:0], sda_bus};
          s_pos++;
        end else if (s_pos == 8) begin
          if (s_tx) begin
            m_ack = sda_bus;
            obs_q.push_back({EV_A, 15'h0000, sda_bus}); obs_t.push_back(cyc);
          end
          s_pos = 9;
        end
      end else if (!ads_scl && p_scl) begin
        cur = (s_tx_idx == 1) ? tx_lsb : tx_msb;
        if (s_pos == 8) begin
          if (!s_tx) begin
            obs_q.push_back({EV_B, 8'h00, s_byte}); obs_t.push_back(cyc);
            if (s_rx_cnt == nack_at) begin
              slave_low = 1'b0;
            end else begin
              slave_low = 1'b1;
              if (s_byte_no == 0 && s_byte[0]) s_go_tx = 1'b1;
            end
            s_rx_cnt++;
          end else begin
            slave_low = 1'b0;
          end
        end else if (s_pos == 9) begin
          s_pos = 0;
          s_byte_no++;
          if (s_tx) begin
            if (m_ack == 1'b0 && s_tx_idx == 0) begin
              s_tx_idx = 1;
              slave_low = !tx_lsb[7];
            end else begin
              s_tx = 1'b0;
              slave_low = 1'b0;
            end
          end else if (s_go_tx) begin
            s_go_tx = 1'b0;
            s_tx = 1'b1;
            s_tx_idx = 0;
            slave_low = !tx_msb[7];
          end else begin
            slave_low = 1'b0;
          end
        end else if (s_tx && s_pos >= 1 && s_pos <= 7) begin
          slave_low = !cur[7 - s_pos];
        end
      end
      p_scl = ads_scl;
      p_sda = sda_bus;
    end
  end

  // Monitor: pops expectations whenever the bus or ad_voltage presents an event
  initial begin : monitor
    logic [19:0] ev, ex;
    logic [15:0] last_v;
    int t;
    last_v = 16'h0000;
    forever begin
      @(negedge clk);
      while (obs_q.size() != 0) begin
        ev = obs_q.pop_front();
        t = obs_t.pop_front();
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: actual %0h required none", ev);
        end else begin
          ex = exp_q.pop_front();
          if (ev !== ex) begin
            n_fail++;
            $display("FAIL bus_event: actual %0h required %0h", ev, ex);
          end
        end
        if (ev[19:16] == EV_P) last_stop = t;
      end
      if (ad_voltage !== last_v) begin
        if (slave_en && rst_n) begin
          ev = {EV_V, ad_voltage};
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_voltage: actual %0h required none", ad_voltage);
          end else begin
            ex = exp_q.pop_front();
            if (ev !== ex) begin
              n_fail++;
              $display("FAIL voltage_event: actual %0h required %0h", ev, ex);
            end
          end
          check_range("voltage_after_stop", cyc - last_stop, 95, 105);
        end
        last_v = ad_voltage;
      end
    end
  end

  function automatic void model_write(input int nack);
    logic [7:0] b[4];
    b[0] = 8'h90; b[1] = 8'h01; b[2] = 8'h84; b[3] = 8'h83;
    push_ev(EV_S, 16'h0);
    for (int i = 0; i < 4; i++) begin
      push_ev(EV_B, {8'h00, b[i]});
      if (i == nack) break;
    end
    push_ev(EV_P, 16'h0);
  endfunction

  function automatic void model_read(input int nack, input logic [7:0] m, input logic [7:0] l);
    push_ev(EV_S, 16'h0);
    push_ev(EV_B, 16'h0090);
    if (nack == 0) begin push_ev(EV_P, 16'h0); return; end
    push_ev(EV_B, 16'h0000);
    push_ev(EV_P, 16'h0);
    if (nack == 1) return;
    push_ev(EV_S, 16'h0);
    push_ev(EV_B, 16'h0091);
    if (nack == 2) begin push_ev(EV_P, 16'h0); return; end
    push_ev(EV_A, 16'h0000);
    push_ev(EV_A, 16'h0001);
    push_ev(EV_P, 16'h0);
    if ({m, l} != model_v) push_ev(EV_V, {m, l});
    model_v = {m, l};
  endfunction

  task automatic pulse(input logic w, input logic r);
    @(negedge clk);
    wr_req = w;
    rd_req = r;
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 9000) begin
      @(negedge clk);
      n++;
    end
    check("txn_events_pending", exp_q.size(), 0);
    repeat (250) @(negedge clk);
    check("idle_scl", ads_scl, 1);
    check("idle_sda", sda_bus, 1);
    check("ad_voltage", ad_voltage, model_v);
    exp_q.delete();
  endtask

  task automatic run_txn(input int op, input int nack, input logic [7:0] m, input logic [7:0] l);
    txn_id++;
    nack_at = nack;
    tx_msb = m;
    tx_lsb = l;
    if (op == 1) model_read(nack, m, l);
    else model_write(nack);
    pulse(op != 1, op != 0);
    wait_done();
  endtask

  initial begin : stimulus
    int t0, e0, n, op, nk;
    repeat (3) @(negedge clk);
    check("reset_scl", ads_scl, 1);
    check("reset_sda", sda_bus, 1);
    check("reset_voltage", ad_voltage, 16'h0000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    slave_en = 1'b1;

    e0 = edge_cnt;
    repeat (10000) @(negedge clk);
    check("idle_1ms_edges", edge_cnt - e0, 0);
    check("idle_1ms_scl", ads_scl, 1);
    check("idle_1ms_sda", sda_bus, 1);

    t0 = cyc;
    run_txn(0, -1, 8'h00, 8'h00);
    check_range("write_duration", last_stop - t0, 3750, 3850);

    run_txn(1, -1, 8'h12, 8'h34);
    check("read_result", ad_voltage, 16'h1234);

    run_txn(1, 0, 8'hee, 8'hff);
    check("nack_keeps_voltage", ad_voltage, 16'h1234);

    txn_id++;
    nack_at = -1;
    model_write(-1);
    pulse(1'b1, 1'b1);
    repeat (1000) @(negedge clk);
    pulse(1'b0, 1'b1);
    wait_done();

    // reset while the 0x91 address byte is on the bus
    txn_id++;
    nack_at = -1;
    tx_msb = 8'hab;
    tx_lsb = 8'hcd;
    push_ev(EV_S, 16'h0); push_ev(EV_B, 16'h0090); push_ev(EV_B, 16'h0000);
    push_ev(EV_P, 16'h0); push_ev(EV_S, 16'h0);
    pulse(1'b0, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 9000) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_events_pending", exp_q.size(), 0);
    repeat (400) @(negedge clk);
    slave_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_scl", ads_scl, 1);
    check("midreset_sda", sda_bus, 1);
    check("midreset_voltage", ad_voltage, 16'h0000);
    model_v = 16'h0000;
    exp_q.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    slave_en = 1'b1;
    run_txn(1, -1, 8'h56, 8'h78);
    check("read_after_reset", ad_voltage, 16'h5678);

    for (int i = 0; i < 6; i++) begin
      op = $urandom_range(0, 2);
      nk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (op == 1) ? 2 : 3) : -1;
      run_txn(op, nk, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #(100 * 95000);
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
